// File: rtl/hazard_md_ctrl.sv
// Pipeline hazard/sequencing control and shared multdiv scheduler.
// Optional stall counter when HAZ_PERF_CNT_EN is defined.
module hazard_md_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn_d,
  input  logic [31:0] insn_x,
  input  logic        branch_taken_x,
  input  logic        md_ready,
  output logic        stall_pc,
  output logic        bubble_dx,
  output logic        flush_fd,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        md_busy,
  output logic [4:0]  md_dest,
  output logic        md_wb_en,
  output logic        md_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] R_LINK   = 5'd31;
  localparam logic [4:0] R_STATUS = 5'd30;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } md_state_e;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       md_dest_q;
  logic             md_wb_en_q;
  logic             md_err_q;

  logic [4:0] op_d, rd_d, rs_d, rt_d, alu_d;
  logic [4:0] op_x, rd_x, alu_x;

  assign op_d  = insn_d[31:27];
  assign rd_d  = insn_d[26:22];
  assign rs_d  = insn_d[21:17];
  assign rt_d  = insn_d[16:12];
  assign alu_d = insn_d[6:2];

  assign op_x  = insn_x[31:27];
  assign rd_x  = insn_x[26:22];
  assign alu_x = insn_x[6:2];

  logic unused_bits;
  assign unused_bits = ^{insn_d[11:7], insn_d[1:0],
                         insn_x[21:7], insn_x[1:0]};

  logic is_md_d, is_md_x;
  logic is_mul_x, is_div_x;

  assign is_md_d  = (op_d == OP_RTYPE) &&
                    ((alu_d == ALU_MUL) || (alu_d == ALU_DIV));
  assign is_mul_x = (op_x == OP_RTYPE) && (alu_x == ALU_MUL);
  assign is_div_x = (op_x == OP_RTYPE) && (alu_x == ALU_DIV);
  assign is_md_x  = is_mul_x | is_div_x;

  logic [4:0] src_a, src_b;
  logic       src_a_v, src_b_v;

  // Source registers read by the instruction in decode
  always_comb begin
    src_a   = 5'd0;
    src_b   = 5'd0;
    src_a_v = 1'b0;
    src_b_v = 1'b0;
    unique case (1'b1)
      (op_d == OP_RTYPE): begin
        src_a   = rs_d;
        src_a_v = 1'b1;
        src_b   = rt_d;
        src_b_v = 1'b1;
      end
      (op_d == OP_ADDI) || (op_d == OP_LW): begin
        src_a   = rs_d;
        src_a_v = 1'b1;
      end
      (op_d == OP_SW) || (op_d == OP_BNE) ||
      (op_d == OP_BLT): begin
        src_a   = rd_d;
        src_a_v = 1'b1;
        src_b   = rs_d;
        src_b_v = 1'b1;
      end
      (op_d == OP_JR): begin
        src_a   = rd_d;
        src_a_v = 1'b1;
      end
      (op_d == OP_BEX): begin
        src_a   = R_STATUS;
        src_a_v = 1'b1;
      end
      default: begin
      end
    endcase
  end

  logic [4:0] dst_d;
  logic       dst_v;

  // Destination register written by the instruction in decode
  always_comb begin
    dst_d = 5'd0;
    dst_v = 1'b0;
    unique case (1'b1)
      (op_d == OP_RTYPE) || (op_d == OP_ADDI) ||
      (op_d == OP_LW): begin
        dst_d = rd_d;
        dst_v = 1'b1;
      end
      (op_d == OP_JAL): begin
        dst_d = R_LINK;
        dst_v = 1'b1;
      end
      (op_d == OP_SETX): begin
        dst_d = R_STATUS;
        dst_v = 1'b1;
      end
      default: begin
      end
    endcase
  end

  function automatic logic reads_reg(
    input logic [4:0] r,
    input logic [4:0] a,
    input logic       av,
    input logic [4:0] b,
    input logic       bv
  );
    return (r != 5'd0) &&
           ((av && (a == r)) || (bv && (b == r)));
  endfunction

  logic load_use;
  logic md_haz;
  logic stall_raw;

  // Hazard detection; r0 never creates a dependency
  always_comb begin
    load_use = (op_x == OP_LW) &&
               reads_reg(rd_x, src_a, src_a_v, src_b, src_b_v);
    md_haz   = (state_q != ST_IDLE) &&
               (reads_reg(md_dest_q, src_a, src_a_v,
                          src_b, src_b_v) ||
                (dst_v && (dst_d != 5'd0) &&
                 (dst_d == md_dest_q)) ||
                is_md_d);
    stall_raw = load_use | md_haz;
  end

  // A taken branch squashes both younger stages and wins over stalls
  always_comb begin
    flush_fd  = branch_taken_x;
    bubble_dx = branch_taken_x | stall_raw;
    stall_pc  = stall_raw & ~branch_taken_x;
  end

  logic start_ok;
  assign start_ok      = (state_q == ST_IDLE);
  assign md_start_mult = start_ok & is_mul_x;
  assign md_start_div  = start_ok & is_div_x;

  // Multdiv scheduler: issue, wait for ready or timeout, one-cycle writeback
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      md_dest_q  <= 5'd0;
      md_wb_en_q <= 1'b0;
      md_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          md_wb_en_q <= 1'b0;
          md_err_q   <= 1'b0;
          if (is_md_x) begin
            md_dest_q <= rd_x;
            cnt_q     <= '0;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (md_ready) begin
            state_q    <= ST_WB;
            md_wb_en_q <= 1'b1;
            md_err_q   <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q    <= ST_WB;
            md_wb_en_q <= 1'b1;
            md_err_q   <= 1'b1;
          end
        end
        ST_WB: begin
          md_wb_en_q <= 1'b0;
          md_err_q   <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          md_wb_en_q <= 1'b0;
          md_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy  = (state_q != ST_IDLE);
  assign md_dest  = md_dest_q;
  assign md_wb_en = md_wb_en_q;
  assign md_err   = md_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign stall_cnt_d = stall_pc ? stall_cnt_q + 32'd1
                                : stall_cnt_q;

  // Free-running count of PC-stall cycles, wraps naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Scoreboard bench for hazard_md_ctrl.
// Directed vectors; monitor compares at the falling edge.
module tb_hazard_md_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] insn_d;
  logic [31:0] insn_x;
  logic        branch_taken_x;
  logic        md_ready;
  logic        stall_pc;
  logic        bubble_dx;
  logic        flush_fd;
  logic        md_start_mult;
  logic        md_start_div;
  logic        md_busy;
  logic [4:0]  md_dest;
  logic        md_wb_en;
  logic        md_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_md_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .insn_d         (insn_d),
    .insn_x         (insn_x),
    .branch_taken_x (branch_taken_x),
    .md_ready       (md_ready),
    .stall_pc       (stall_pc),
    .bubble_dx      (bubble_dx),
    .flush_fd       (flush_fd),
    .md_start_mult  (md_start_mult),
    .md_start_div   (md_start_div),
    .md_busy        (md_busy),
    .md_dest        (md_dest),
    .md_wb_en       (md_wb_en),
    .md_err         (md_err)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [12:0] e;
    logic [12:0] m;
  } exp_t;

  exp_t sbq[$];
  int   compared = 0;
  int   mismatched = 0;

  localparam logic [12:0] M_ALL   = 13'h1FFF;
  localparam logic [12:0] M_NOERR = 13'h1FFE;

  function automatic logic [12:0] ev(
    bit st, bit bu, bit fl, bit sm, bit sd,
    bit by, logic [4:0] ds, bit wb, bit er);
    return {st, bu, fl, sm, sd, by, ds, wb, er};
  endfunction

  function automatic logic [31:0] rt(
    logic [4:0] rd, logic [4:0] rs,
    logic [4:0] rtr, logic [4:0] alu);
    return {5'b00000, rd, rs, rtr, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] it(
    logic [4:0] op, logic [4:0] rd,
    logic [4:0] rs, logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  logic [12:0] act;
  assign act = {stall_pc, bubble_dx, flush_fd,
                md_start_mult, md_start_div, md_busy,
                md_dest, md_wb_en, md_err};

  // Monitor: pop one expectation per presented cycle
  always @(negedge clock) begin
    exp_t t;
    if (sbq.size() > 0) begin
      t = sbq.pop_front();
      compared++;
      if (((act ^ t.e) & t.m) != 13'd0) begin
        mismatched++;
        $display("FAIL %s: got %b want %b (mask %b)",
                 t.nm, act, t.e, t.m);
      end
    end
  end

  task automatic step(
    input string       nm,
    input bit          rn,
    input logic [31:0] d,
    input logic [31:0] x,
    input bit          br,
    input bit          rdy,
    input bit          chk,
    input logic [12:0] e,
    input logic [12:0] m);
    exp_t t;
    @(posedge clock);
    #1;
    reset_n        = rn;
    insn_d         = d;
    insn_x         = x;
    branch_taken_x = br;
    md_ready       = rdy;
    if (chk) begin
      t.nm = nm;
      t.e  = e;
      t.m  = m;
      sbq.push_back(t);
    end
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] d,
    input logic [31:0] x,
    input bit          br,
    input bit          rdy,
    input logic [12:0] e);
    step(nm, 1'b1, d, x, br, rdy, 1'b1, e, M_ALL);
  endtask

  task automatic run(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++)
      step("", 1'b1, d, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  localparam logic [4:0] LW   = 5'b01000;
  localparam logic [4:0] SW   = 5'b00111;
  localparam logic [4:0] ADDI = 5'b00101;
  localparam logic [4:0] JR   = 5'b00100;
  localparam logic [4:0] BEX  = 5'b10110;
  localparam logic [4:0] MUL  = 5'b00110;
  localparam logic [4:0] DIV  = 5'b00111;

  logic [31:0] lw5, lw0, lw30, add6, sw3, add7;

  initial begin
    reset_n        = 1'b0;
    insn_d         = 32'h0;
    insn_x         = 32'h0;
    branch_taken_x = 1'b0;
    md_ready       = 1'b0;

    lw5  = it(LW, 5'd5, 5'd1, 17'd0);
    lw0  = it(LW, 5'd0, 5'd1, 17'd0);
    lw30 = it(LW, 5'd30, 5'd1, 17'd0);
    add6 = rt(5'd6, 5'd5, 5'd2, 5'd0);
    sw3  = it(SW, 5'd3, 5'd1, 17'd0);
    add7 = rt(5'd7, 5'd1, 5'd2, 5'd0);

    step("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,5'd0,0,0), M_ALL);

    // load-use
    chk("lu_add", add6, lw5, 0, 0, ev(1,1,0,0,0,0,5'd0,0,0));
    chk("lu_gone", add6, 32'h0, 0, 1, ev(0,0,0,0,0,0,5'd0,0,0));
    chk("lu_r0", rt(5'd6, 5'd0, 5'd2, 5'd0), lw0, 0, 0,
        ev(0,0,0,0,0,0,5'd0,0,0));
    chk("lu_sw", it(SW, 5'd5, 5'd1, 17'd0), lw5, 0, 0,
        ev(1,1,0,0,0,0,5'd0,0,0));
    chk("lu_addi_rt", it(ADDI, 5'd6, 5'd1, {5'd5, 12'd0}),
        lw5, 0, 0, ev(0,0,0,0,0,0,5'd0,0,0));
    chk("lu_jr", it(JR, 5'd5, 5'd0, 17'd0), lw5, 0, 0,
        ev(1,1,0,0,0,0,5'd0,0,0));
    chk("lu_bex", it(BEX, 5'd0, 5'd0, 17'd0), lw30, 0, 0,
        ev(1,1,0,0,0,0,5'd0,0,0));
    chk("branch", add6, lw5, 1, 0, ev(0,1,1,0,0,0,5'd0,0,0));

    // mul r3, ready on cycle 17
    chk("mul_start", 32'h0, rt(5'd3, 5'd1, 5'd2, MUL), 0, 0,
        ev(0,0,0,1,0,0,5'd0,0,0));
    chk("busy_sw3", sw3, 32'h0, 0, 0, ev(1,1,0,0,0,1,5'd3,0,0));
    chk("busy_add7", add7, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd3,0,0));
    chk("busy_md_d", rt(5'd8, 5'd1, 5'd2, DIV), 32'h0, 0, 0,
        ev(1,1,0,0,0,1,5'd3,0,0));
    chk("busy_waw", rt(5'd3, 5'd1, 5'd2, 5'd0), 32'h0, 0, 0,
        ev(1,1,0,0,0,1,5'd3,0,0));
    chk("busy_rt", rt(5'd9, 5'd1, 5'd3, 5'd0), 32'h0, 0, 0,
        ev(1,1,0,0,0,1,5'd3,0,0));
    run(11, add7);
    chk("mul_rdy", sw3, 32'h0, 0, 1, ev(1,1,0,0,0,1,5'd3,0,0));
    chk("mul_wb", sw3, 32'h0, 0, 0, ev(1,1,0,0,0,1,5'd3,1,0));
    chk("mul_rel", sw3, 32'h0, 0, 0, ev(0,0,0,0,0,0,5'd3,0,0));

    // div r4, timeout
    chk("div_start", 32'h0, rt(5'd4, 5'd1, 5'd2, DIV), 0, 0,
        ev(0,0,0,0,1,0,5'd3,0,0));
    run(39, 32'h0);
    chk("to_c40", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd4,0,0));
    chk("to_wb", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd4,1,1));
    step("to_idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,5'd4,0,0), M_NOERR);

    // mul r2, ready coincides with timeout
    chk("both_start", 32'h0, rt(5'd2, 5'd1, 5'd3, MUL), 0, 0,
        ev(0,0,0,1,0,0,5'd4,0,0));
    run(39, 32'h0);
    chk("both_rdy", 32'h0, 32'h0, 0, 1, ev(0,0,0,0,0,1,5'd2,0,0));
    chk("both_wb", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd2,1,0));
    step("both_idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,5'd2,0,0), M_NOERR);

    // mul r0
    chk("r0_start", 32'h0, rt(5'd0, 5'd1, 5'd2, MUL), 0, 0,
        ev(0,0,0,1,0,0,5'd2,0,0));
    chk("r0_rd", rt(5'd6, 5'd0, 5'd0, 5'd0), 32'h0, 0, 0,
        ev(0,0,0,0,0,1,5'd0,0,0));
    chk("r0_rdy", 32'h0, 32'h0, 0, 1, ev(0,0,0,0,0,1,5'd0,0,0));
    chk("r0_wb", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd0,1,0));

    // reset while busy, then div r6
    chk("rst_start", 32'h0, rt(5'd5, 5'd1, 5'd2, MUL), 0, 0,
        ev(0,0,0,1,0,0,5'd0,0,0));
    run(4, 32'h0);
    chk("rst_busy", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd5,0,0));
    step("rst_low", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
         ev(0,0,0,0,0,0,5'd0,0,0), M_ALL);
    chk("rst_rel", 32'h0, 32'h0, 0, 1, ev(0,0,0,0,0,0,5'd0,0,0));
    chk("rst_nowb", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,0,5'd0,0,0));
    chk("div_go", 32'h0, rt(5'd6, 5'd1, 5'd2, DIV), 0, 0,
        ev(0,0,0,0,1,0,5'd0,0,0));
    chk("div_busy", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd6,0,0));
    chk("div_rdy", 32'h0, 32'h0, 0, 1, ev(0,0,0,0,0,1,5'd6,0,0));
    chk("div_wb", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,1,5'd6,1,0));
    chk("div_idle", 32'h0, 32'h0, 0, 0, ev(0,0,0,0,0,0,5'd6,0,0));

    repeat (3) @(negedge clock);
    #1;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
